serial_shift_out: RTL and testbench

SERIAL_SHIFT_OUT -- requirements
Module: serial_shift_out

---
 rtl/serial_pkg.sv | 10 +
 rtl/serial_shift_out.sv | 125 ++++++++++++
 tb/tb_serial_shift_out.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift blocks.
package serial_pkg;

    // Shifter state encoding, shared by the output and future input shifters.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } serial_state_e;

endpackage : serial_pkg

// File: rtl/serial_shift_out.sv
// Parallel-to-serial shifter: one-shot or rotating frames, all outputs registered.
module serial_shift_out
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          ROTATE     = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             stop,
    output logic             dout,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_state_e    r_state;
    logic [WIDTH-1:0] r_buf;
    logic [CW-1:0]    r_cnt;
    logic             r_dout;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_load_ready;

    serial_state_e    w_state_nxt;
    logic [WIDTH-1:0] w_buf_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_buf_rot;
    logic             w_accept;
    logic             w_dout_nxt;
    logic             w_busy_nxt;
    logic             w_frame_done_nxt;
    logic             w_load_ready_nxt;

    // Buffer rotated one place toward the output end.
    assign w_buf_rot = MSB_FIRST ? {r_buf[WIDTH-2:0], r_buf[WIDTH-1]}
                                 : {r_buf[0], r_buf[WIDTH-1:1]};

    // Registered ready already reflects state/counter, so use it to qualify loads.
    assign w_accept = load_valid & r_load_ready;

    // Next state, buffer and counter; frame boundary priority is load, rotate, idle.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_buf_nxt   = din;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (r_cnt != LAST) begin
                    w_buf_nxt = w_buf_rot;
                    w_cnt_nxt = r_cnt + CW'(1);
                end else if (w_accept) begin
                    w_buf_nxt = din;
                    w_cnt_nxt = '0;
                end else if (ROTATE && !stop) begin
                    w_buf_nxt = w_buf_rot;
                    w_cnt_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_buf_nxt   = w_buf_rot;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decodes of the next state, so the registered outputs track the state exactly.
    always_comb begin
        w_dout_nxt       = IDLE_LEVEL;
        w_busy_nxt       = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_load_ready_nxt = 1'b1;
        if (w_state_nxt == ST_SHIFT) begin
            w_dout_nxt       = MSB_FIRST ? w_buf_nxt[WIDTH-1] : w_buf_nxt[0];
            w_busy_nxt       = 1'b1;
            w_frame_done_nxt = (w_cnt_nxt == LAST);
            w_load_ready_nxt = (w_cnt_nxt == LAST);
        end
    end

    // State, datapath and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_dout       <= IDLE_LEVEL;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dout       <= w_dout_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_load_ready <= w_load_ready_nxt;
        end
    end

    assign dout       = r_dout;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign load_ready = r_load_ready;

endmodule : serial_shift_out

// File: tb/tb_serial_shift_out.sv
// Bench for serial_shift_out: three parameterisations against a bit-queue model.
module tb_serial_shift_out;

    localparam int unsigned W = 16;
    // Per-instance parameters, bit d belongs to instance d.
    localparam logic [2:0] MSBF = 3'b101;
    localparam logic [2:0] ROT  = 3'b100;
    localparam logic [2:0] IDL  = 3'b101;

    typedef struct {
        logic         lv;
        logic [W-1:0] din;
        logic         dout_m;
        logic         dout_l;
        logic         busy;
        logic         fd;
        logic         rdy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   lv, stp, dout, busy, fd, rdy;
    logic [W-1:0] din [3];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: queue of bits still to appear on dout, head is the bit showing now.
    bit           mq  [3][$];
    logic [W-1:0] frm [3];

    always #5 clk = ~clk;

    serial_shift_out #(.WIDTH(W), .MSB_FIRST(1'b1), .ROTATE(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .load_valid(lv[0]), .load_ready(rdy[0]),
        .stop(stp[0]), .dout(dout[0]), .busy(busy[0]), .frame_done(fd[0]));

    serial_shift_out #(.WIDTH(W), .MSB_FIRST(1'b0), .ROTATE(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .load_valid(lv[1]), .load_ready(rdy[1]),
        .stop(stp[1]), .dout(dout[1]), .busy(busy[1]), .frame_done(fd[1]));

    serial_shift_out #(.WIDTH(W), .MSB_FIRST(1'b1), .ROTATE(1'b1), .IDLE_LEVEL(1'b1)) u_rot (
        .clk(clk), .rst_n(rst_n), .din(din[2]), .load_valid(lv[2]), .load_ready(rdy[2]),
        .stop(stp[2]), .dout(dout[2]), .busy(busy[2]), .frame_done(fd[2]));

    task automatic chk(input string nm, input int d, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %b want %b", nm, d, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic push_frame(input int d, input logic [W-1:0] f);
        for (int k = 0; k < W; k++)
            mq[d].push_back(MSBF[d] ? f[W-1-k] : f[k]);
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            int n;
            bit acc;
            n   = mq[d].size();
            acc = lv[d] && (n <= 1);
            if (n > 0) void'(mq[d].pop_front());
            if (acc) begin
                frm[d] = din[d];
                push_frame(d, din[d]);
            end else if (n == 1 && ROT[d] && !stp[d]) begin
                push_frame(d, frm[d]);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_model(input int d);
        int n;
        n = mq[d].size();
        chk("dout", d, dout[d], (n > 0) ? logic'(mq[d][0]) : IDL[d]);
        chk("busy", d, busy[d], n > 0);
        chk("frame_done", d, fd[d], n == 1);
        chk("load_ready", d, rdy[d], n <= 1);
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) mq[d].delete();
    endtask

    initial begin
        vec_t         tbl [20];
        logic [W-1:0] pat_m, pat_l;
        int           bits, guard, fd1, fd2;

        lv = '0;
        stp = '0;
        for (int d = 0; d < 3; d++) din[d] = '0;
        model_clear();

        // Reset state while rst_n is low.
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("rst_dout", d, dout[d], IDL[d]);
            chk("rst_busy", d, busy[d], 1'b0);
            chk("rst_fd", d, fd[d], 1'b0);
            chk("rst_rdy", d, rdy[d], 1'b1);
        end
        rst_n = 1'b1;

        // Directed table: A5C3 on MSB- and LSB-first instances, with an ignored pulse at bit 5.
        pat_m = 16'b1010_0101_1100_0011;
        pat_l = 16'b1100_0011_1010_0101;
        for (int i = 0; i < 20; i++)
            tbl[i] = '{lv: 1'b0, din: '0, dout_m: 1'b1, dout_l: 1'b0, busy: 1'b0, fd: 1'b0, rdy: 1'b1};
        for (int k = 0; k < 16; k++) begin
            tbl[k].dout_m = pat_m[15-k];
            tbl[k].dout_l = pat_l[15-k];
            tbl[k].busy   = 1'b1;
            tbl[k].fd     = (k == 15);
            tbl[k].rdy    = (k == 15);
        end
        tbl[0].lv  = 1'b1;
        tbl[0].din = 16'hA5C3;
        tbl[6].lv  = 1'b1;
        tbl[6].din = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            lv[0] = tbl[i].lv;  din[0] = tbl[i].din;
            lv[1] = tbl[i].lv;  din[1] = tbl[i].din;
            tick();
            chk("tbl_dout", 0, dout[0], tbl[i].dout_m);
            chk("tbl_busy", 0, busy[0], tbl[i].busy);
            chk("tbl_fd", 0, fd[0], tbl[i].fd);
            chk("tbl_rdy", 0, rdy[0], tbl[i].rdy);
            chk("tbl_dout", 1, dout[1], tbl[i].dout_l);
            chk("tbl_busy", 1, busy[1], tbl[i].busy);
            chk("tbl_fd", 1, fd[1], tbl[i].fd);
        end
        lv = '0;

        // Back-to-back FFFF then 0000, second load presented during the 16th bit.
        lv[0] = 1'b1; din[0] = 16'hFFFF;
        tick();
        lv[0] = 1'b0;
        chk_model(0);
        fd1 = -1; fd2 = -1;
        for (int k = 1; k < 16; k++) begin
            tick();
            chk_model(0);
            if (fd[0] === 1'b1) fd1 = cyc;
        end
        chk("b2b_last_fd", 0, fd[0], 1'b1);
        lv[0] = 1'b1; din[0] = 16'h0000;
        tick();
        lv[0] = 1'b0;
        chk_model(0);
        chk("b2b_gap_dout", 0, dout[0], 1'b0);
        chk("b2b_gap_busy", 0, busy[0], 1'b1);
        for (int k = 1; k < 18; k++) begin
            tick();
            chk_model(0);
            if (fd[0] === 1'b1 && fd2 < 0) fd2 = cyc;
        end
        chk_int("b2b_fd_spacing", fd2 - fd1, 16);

        // Rotate 8001 for three frames, stop raised mid third frame.
        lv[2] = 1'b1; din[2] = 16'h8001;
        tick();
        lv[2] = 1'b0;
        chk_model(2);
        bits = 1;
        guard = 0;
        while (busy[2] === 1'b1 && guard < 100) begin
            if (bits == 40) stp[2] = 1'b1;
            tick();
            chk_model(2);
            if (busy[2] === 1'b1) bits++;
            guard++;
        end
        stp[2] = 1'b0;
        chk_int("rotate_length", bits, 48);

        // Reset at bit 7 of a frame, then a clean frame afterwards.
        lv[0] = 1'b1; din[0] = 16'h3C5A;
        tick();
        lv[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk_model(0);
        end
        #3 rst_n = 1'b0;
        model_clear();
        #1;
        chk("midrst_dout", 0, dout[0], 1'b1);
        chk("midrst_busy", 0, busy[0], 1'b0);
        chk("midrst_fd", 0, fd[0], 1'b0);
        chk("midrst_rdy", 0, rdy[0], 1'b1);
        @(posedge clk);
        #1;
        chk("midrst_hold_fd", 0, fd[0], 1'b0);
        chk("midrst_hold_busy", 0, busy[0], 1'b0);
        #2 rst_n = 1'b1;
        lv[0] = 1'b1; din[0] = 16'h9E21;
        tick();
        lv[0] = 1'b0;
        chk_model(0);
        for (int k = 0; k < 18; k++) begin
            tick();
            chk_model(0);
        end

        // Randomised traffic on all instances against the model.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 3; d++) begin
                lv[d]  = ($urandom_range(0, 3) == 0);
                din[d] = 16'($urandom);
                stp[d] = ($urandom_range(0, 7) == 0);
            end
            tick();
            for (int d = 0; d < 3; d++) chk_model(d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_serial_shift_out
